// File: rtl/ahb3lite_pkg.sv
// ---------------------------------------------------------------------------
// ahb3lite_pkg
// Shared AHB3-Lite bus encodings plus the arbiter state type.
//   HTRANS_state : transfer type on the address phase
//   HBURST_Type  : burst type on the address phase
//   HRESP_state  : slave response
//   arb_state    : arbiter ownership state
// Helpers classify a transfer type for beat counting and handover points.
// ---------------------------------------------------------------------------
package ahb3lite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } HTRANS_state;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } HBURST_Type;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } HRESP_state;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state;

    localparam int ARB_MAX_MASTERS = 8;

    // A beat that moves data and therefore counts against the hold budget.
    function automatic logic trans_is_beat(input HTRANS_state t);
        return (t == NONSEQ) || (t == SEQ);
    endfunction

    // Only IDLE/NONSEQ start a new transfer, so the bus may change hands
    // there without splitting a burst.
    function automatic logic trans_is_boundary(input HTRANS_state t);
        return (t == IDLE) || (t == NONSEQ);
    endfunction

endpackage

// File: rtl/ahb3lite_rr_picker.sv
// ---------------------------------------------------------------------------
// ahb3lite_rr_picker
// Combinational round-robin selector: the first set bit of req at or after
// rr_ptr, wrapping modulo NUM_MASTERS.
//   req      in  NUM_MASTERS  request vector
//   rr_ptr   in  MW           index with highest priority this cycle
//   pick_oh  out NUM_MASTERS  one-hot winner (zero when nobody requests)
//   pick_idx out MW           winner index (zero when nobody requests)
//   any_req  out 1            at least one request present
// ---------------------------------------------------------------------------
module ahb3lite_rr_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MW-1:0]          rr_ptr,
    output logic [NUM_MASTERS-1:0] pick_oh,
    output logic [MW-1:0]          pick_idx,
    output logic                   any_req
);

    always_comb begin
        int j;
        j        = 0;
        pick_oh  = '0;
        pick_idx = '0;
        any_req  = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            j = (int'(rr_ptr) + k) % NUM_MASTERS;
            if (!any_req && req[j]) begin
                any_req     = 1'b1;
                pick_idx    = MW'(j);
                pick_oh[j]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb3lite_arbiter.sv
// ---------------------------------------------------------------------------
// ahb3lite_arbiter
// Shares one AHB3-Lite slave port between NUM_MASTERS masters using
// round-robin arbitration with handover only at burst boundaries.
//   HCLK, HRESET          clock, synchronous active-high reset
//   HBUSREQ               per-master bus request
//   M_HADDR/HTRANS/HWRITE/HSIZE/HBURST  per-master address/control
//   HREADY, HRDATA_En     slave ready, slave read-data valid
//   HGRANT                one-hot grant (registered)
//   HMASTER / HMASTER_D   address-phase / data-phase owner (registered)
//   HADDR..HBURST         address/control muxed from HMASTER
//   o_HRDATA_En           HRDATA_En steered to the data-phase owner
// ---------------------------------------------------------------------------
module ahb3lite_arbiter
    import ahb3lite_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_BEATS      = 16,
    parameter int MW             = $clog2(NUM_MASTERS)
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [NUM_MASTERS-1:0]    HBUSREQ,
    input  logic [NUM_MASTERS*32-1:0] M_HADDR,
    input  HTRANS_state               M_HTRANS [NUM_MASTERS],
    input  logic [NUM_MASTERS-1:0]    M_HWRITE,
    input  logic [NUM_MASTERS*3-1:0]  M_HSIZE,
    input  HBURST_Type                M_HBURST [NUM_MASTERS],
    input  logic                      HREADY,
    input  logic                      HRDATA_En,
    output logic [NUM_MASTERS-1:0]    HGRANT,
    output logic [MW-1:0]             HMASTER,
    output logic [MW-1:0]             HMASTER_D,
    output logic [31:0]               HADDR,
    output HTRANS_state               HTRANS,
    output logic                      HWRITE,
    output logic [2:0]                HSIZE,
    output HBURST_Type                HBURST,
    output logic [NUM_MASTERS-1:0]    o_HRDATA_En
);

    localparam int            BW      = $clog2(MAX_BEATS + 1);
    localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

    function automatic logic [MW-1:0] wrap_inc(input logic [MW-1:0] i);
        if (int'(i) >= NUM_MASTERS - 1) return '0;
        return i + MW'(1);
    endfunction

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [MW-1:0] i);
        logic [NUM_MASTERS-1:0] o;
        o    = '0;
        o[i] = 1'b1;
        return o;
    endfunction

    arb_state               state;
    logic [MW-1:0]          rr_ptr;
    logic [BW-1:0]          beat_cnt;

    logic [NUM_MASTERS-1:0] pick_oh;
    logic [MW-1:0]          pick_idx;
    logic                   any_req;

    logic                   owner_req;
    HTRANS_state            owner_trans;
    logic                   others_req;
    logic                   cnt_full;
    logic                   handover;

    ahb3lite_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .MW          (MW)
    ) u_picker (
        .req      (HBUSREQ),
        .rr_ptr   (rr_ptr),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .any_req  (any_req)
    );

    // Address/control follow the address-phase owner with no added latency.
    always_comb begin
        HADDR  = M_HADDR[int'(HMASTER)*32 +: 32];
        HTRANS = M_HTRANS[HMASTER];
        HWRITE = M_HWRITE[HMASTER];
        HSIZE  = M_HSIZE[int'(HMASTER)*3 +: 3];
        HBURST = M_HBURST[HMASTER];
    end

    always_comb begin
        o_HRDATA_En = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            o_HRDATA_En[i] = HRDATA_En && (HMASTER_D == MW'(i));
    end

    // rr_ptr already sits one past the owner, so a still-requesting owner
    // naturally ranks last when the picker runs at a handover point.
    always_comb begin
        owner_req   = HBUSREQ[HMASTER];
        owner_trans = M_HTRANS[HMASTER];
        others_req  = |(HBUSREQ & ~onehot(HMASTER));
        cnt_full    = (beat_cnt >= BW'(MAX_BEATS));
        handover    = trans_is_boundary(owner_trans) &&
                      (!owner_req || (cnt_full && others_req));
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ARB_IDLE;
            HGRANT    <= onehot(DEF_IDX);
            HMASTER   <= DEF_IDX;
            HMASTER_D <= DEF_IDX;
            rr_ptr    <= wrap_inc(DEF_IDX);
            beat_cnt  <= '0;
        end else begin
            if (HREADY)
                HMASTER_D <= HMASTER;

            case (state)
                ARB_IDLE: begin
                    if (HREADY && any_req) begin
                        HGRANT   <= pick_oh;
                        HMASTER  <= pick_idx;
                        rr_ptr   <= wrap_inc(pick_idx);
                        beat_cnt <= '0;
                        state    <= ARB_OWN;
                    end
                end

                ARB_OWN: begin
                    if (HREADY) begin
                        if (handover) begin
                            beat_cnt <= '0;
                            if (any_req) begin
                                HGRANT  <= pick_oh;
                                HMASTER <= pick_idx;
                                rr_ptr  <= wrap_inc(pick_idx);
                                state   <= ARB_OWN;
                            end else begin
                                HGRANT  <= onehot(DEF_IDX);
                                HMASTER <= DEF_IDX;
                                rr_ptr  <= wrap_inc(DEF_IDX);
                                state   <= ARB_IDLE;
                            end
                        end else if (trans_is_beat(owner_trans) && !cnt_full) begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end

                default: begin
                    state     <= ARB_IDLE;
                    HGRANT    <= onehot(DEF_IDX);
                    HMASTER   <= DEF_IDX;
                    HMASTER_D <= DEF_IDX;
                    rr_ptr    <= wrap_inc(DEF_IDX);
                    beat_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb3lite_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb3lite_arbiter
// Directed bench for ahb3lite_arbiter (4 masters, default master 0,
// MAX_BEATS 16) with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_ahb3lite_arbiter;
    import ahb3lite_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [3:0]  HBUSREQ;
    logic [127:0] M_HADDR;
    HTRANS_state M_HTRANS [4];
    logic [3:0]  M_HWRITE;
    logic [11:0] M_HSIZE;
    HBURST_Type  M_HBURST [4];
    logic        HREADY;
    logic        HRDATA_En;
    logic [3:0]  HGRANT;
    logic [1:0]  HMASTER;
    logic [1:0]  HMASTER_D;
    logic [31:0] HADDR;
    HTRANS_state HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    HBURST_Type  HBURST;
    logic [3:0]  o_HRDATA_En;

    int n_chk  = 0;
    int n_pass = 0;

    ahb3lite_arbiter #(
        .NUM_MASTERS    (4),
        .DEFAULT_MASTER (0),
        .MAX_BEATS      (16)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HBUSREQ     (HBUSREQ),
        .M_HADDR     (M_HADDR),
        .M_HTRANS    (M_HTRANS),
        .M_HWRITE    (M_HWRITE),
        .M_HSIZE     (M_HSIZE),
        .M_HBURST    (M_HBURST),
        .HREADY      (HREADY),
        .HRDATA_En   (HRDATA_En),
        .HGRANT      (HGRANT),
        .HMASTER     (HMASTER),
        .HMASTER_D   (HMASTER_D),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .o_HRDATA_En (o_HRDATA_En)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESET    = 1'b1;
        HBUSREQ   = 4'b0000;
        HREADY    = 1'b1;
        HRDATA_En = 1'b0;
        M_HWRITE  = 4'b0001;
        M_HSIZE   = {3'd0, 3'd1, 3'd0, 3'd2};
        for (int i = 0; i < 4; i++) begin
            M_HADDR[i*32 +: 32] = 32'hA000_0000 + 32'(i * 16);
            M_HTRANS[i] = IDLE;
            M_HBURST[i] = INCR;
        end
        M_HBURST[0] = INCR4;

        // Reset state
        tick();
        tick();
        M_HTRANS[0] = NONSEQ;
        #1;
        check("rst_grant",   32'(HGRANT),      32'h1);
        check("rst_master",  32'(HMASTER),     32'h0);
        check("rst_master_d",32'(HMASTER_D),   32'h0);
        check("rst_htrans",  32'(HTRANS),      32'h2);
        check("rst_haddr",   HADDR,            32'hA000_0000);
        check("rst_rden",    32'(o_HRDATA_En), 32'h0);
        check("rst_state",   32'(dut.state),   32'h0);
        check("rst_cnt",     32'(dut.beat_cnt),32'h0);
        M_HTRANS[0] = IDLE;
        HRESET = 1'b0;

        // Simultaneous requests 1 and 3: round robin from pointer 1 picks 1
        HBUSREQ = 4'b1010;
        tick();
        check("rr_first_grant", 32'(HGRANT),    32'h2);
        check("rr_first_mst",   32'(HMASTER),   32'h1);
        check("rr_first_md",    32'(HMASTER_D), 32'h0);
        check("rr_first_addr",  HADDR,          32'hA000_0010);
        check("rr_first_state", 32'(dut.state), 32'h1);
        M_HTRANS[1] = NONSEQ;
        tick();
        check("rr_beat1_grant", 32'(HGRANT),     32'h2);
        check("rr_beat1_cnt",   32'(dut.beat_cnt),32'h1);
        check("rr_beat1_md",    32'(HMASTER_D),  32'h1);
        HBUSREQ = 4'b1000;
        M_HTRANS[1] = IDLE;
        tick();
        check("rr_drop_grant", 32'(HGRANT),      32'h8);
        check("rr_drop_mst",   32'(HMASTER),     32'h3);
        check("rr_drop_cnt",   32'(dut.beat_cnt),32'h0);
        HBUSREQ = 4'b0010;
        tick();
        check("rr_wrap_grant", 32'(HGRANT), 32'h2);

        // Master 2 long INCR burst while master 0 waits
        HBUSREQ = 4'b0100;
        tick();
        check("burst_grant2", 32'(HGRANT), 32'h4);
        HBUSREQ = 4'b0101;
        M_HTRANS[2] = NONSEQ;
        tick();
        check("burst_nonseq_grant", 32'(HGRANT), 32'h4);
        M_HTRANS[2] = SEQ;
        for (int b = 0; b < 20; b++) begin
            tick();
            check("burst_seq_grant", 32'(HGRANT), 32'h4);
        end
        check("burst_cnt_sat", 32'(dut.beat_cnt), 32'd16);

        // Boundary reached while the slave stalls: grant must freeze
        M_HTRANS[2] = IDLE;
        HREADY = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("stall_grant", 32'(HGRANT),    32'h4);
            check("stall_mst",   32'(HMASTER),   32'h2);
            check("stall_md",    32'(HMASTER_D), 32'h2);
        end
        HREADY = 1'b1;
        tick();
        check("forced_grant", 32'(HGRANT),    32'h1);
        check("forced_mst",   32'(HMASTER),   32'h0);
        check("forced_md",    32'(HMASTER_D), 32'h2);
        check("forced_cnt",   32'(dut.beat_cnt), 32'h0);
        tick();
        check("forced_md_next", 32'(HMASTER_D), 32'h0);

        // Master 3 in data phase, master 0 in address phase
        HBUSREQ = 4'b1000;
        tick();
        check("steer_grant3", 32'(HGRANT), 32'h8);
        HBUSREQ = 4'b0001;
        M_HTRANS[3] = NONSEQ;
        tick();
        M_HTRANS[3] = IDLE;
        HRDATA_En = 1'b1;
        #1;
        check("steer_mst",   32'(HMASTER),     32'h0);
        check("steer_md",    32'(HMASTER_D),   32'h3);
        check("steer_rden",  32'(o_HRDATA_En), 32'h8);
        check("steer_haddr", HADDR,            32'hA000_0000);
        check("steer_hwrite",32'(HWRITE),      32'h1);
        check("steer_hsize", 32'(HSIZE),       32'h2);
        check("steer_hburst",32'(HBURST),      32'h3);
        HRDATA_En = 1'b0;

        // Reset in the middle of a master 1 burst
        HBUSREQ = 4'b0010;
        tick();
        check("mid_grant1", 32'(HGRANT), 32'h2);
        M_HTRANS[1] = NONSEQ;
        tick();
        M_HTRANS[1] = SEQ;
        tick();
        check("mid_cnt", 32'(dut.beat_cnt), 32'h2);
        HRESET = 1'b1;
        tick();
        check("mid_rst_grant", 32'(HGRANT),       32'h1);
        check("mid_rst_mst",   32'(HMASTER),      32'h0);
        check("mid_rst_cnt",   32'(dut.beat_cnt), 32'h0);
        check("mid_rst_state", 32'(dut.state),    32'h0);
        HRESET = 1'b0;
        M_HTRANS[1] = IDLE;

        // Owner leaves with nobody waiting: bus returns to the default master
        HBUSREQ = 4'b0100;
        tick();
        check("dflt_grant2", 32'(HGRANT), 32'h4);
        HBUSREQ = 4'b0000;
        tick();
        check("dflt_grant",  32'(HGRANT),    32'h1);
        check("dflt_mst",    32'(HMASTER),   32'h0);
        check("dflt_state",  32'(dut.state), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
